// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: sequences DP, LDR/STR and B/BL instructions through
// fetch/decode/execute/writeback steps and gates architectural writes on the
// instruction's condition code, latched at DECODE.
module multicycle_control_unit #(
    parameter logic HALT_ON_UNDEF = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION_OUT,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    localparam state_t UNDEF_NEXT = HALT_ON_UNDEF ? S_HALT : S_FETCH;

    state_t state_q;
    logic   cond_q;

    logic [3:0] cond;
    logic [1:0] op;
    logic       imm;
    logic [3:0] cmd;
    logic       sbit;
    logic [4:0] shamt;
    logic [1:0] sh;
    logic       unused_ir;

    assign cond      = INSTRUCTION_OUT[31:28];
    assign op        = INSTRUCTION_OUT[27:26];
    assign imm       = INSTRUCTION_OUT[25];
    assign cmd       = INSTRUCTION_OUT[24:21];
    assign sbit      = INSTRUCTION_OUT[20];
    assign shamt     = INSTRUCTION_OUT[11:7];
    assign sh        = INSTRUCTION_OUT[6:5];
    assign unused_ir = ^{INSTRUCTION_OUT[19:12], INSTRUCTION_OUT[4:0]};

    logic [2:0] alu_code;
    logic       dp_valid;
    logic       is_cmp;
    logic       cond_ex;

    // Map the data-processing cmd field to an ALU operation and flag unsupported cmds
    always_comb begin
        dp_valid = 1'b1;
        alu_code = 3'b000;
        is_cmp   = (cmd == 4'b1010);
        case (cmd)
            4'b0100: alu_code = 3'b000;
            4'b0010: alu_code = 3'b001;
            4'b0000: alu_code = 3'b010;
            4'b1100: alu_code = 3'b011;
            4'b0001: alu_code = 3'b110;
            4'b1101: alu_code = 3'b100;
            4'b1010: alu_code = 3'b001;
            default: dp_valid = 1'b0;
        endcase
    end

    // Evaluate the condition field against the current {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = FLAGS[2];
            4'b0001: cond_ex = ~FLAGS[2];
            4'b0010: cond_ex = FLAGS[1];
            4'b0011: cond_ex = ~FLAGS[1];
            4'b0100: cond_ex = FLAGS[3];
            4'b0101: cond_ex = ~FLAGS[3];
            4'b0110: cond_ex = FLAGS[0];
            4'b0111: cond_ex = ~FLAGS[0];
            4'b1000: cond_ex = FLAGS[1] & ~FLAGS[2];
            4'b1001: cond_ex = ~FLAGS[1] | FLAGS[2];
            4'b1010: cond_ex = (FLAGS[3] == FLAGS[0]);
            4'b1011: cond_ex = (FLAGS[3] != FLAGS[0]);
            4'b1100: cond_ex = ~FLAGS[2] & (FLAGS[3] == FLAGS[0]);
            4'b1101: cond_ex = FLAGS[2] | (FLAGS[3] != FLAGS[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // State sequencing; the condition outcome is captured once, in DECODE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            cond_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    cond_q <= cond_ex;
                    case (op)
                        2'b00:   state_q <= !dp_valid ? UNDEF_NEXT : (imm ? S_EXECI : S_EXECR);
                        2'b01:   state_q <= S_MEMADR;
                        2'b10:   state_q <= S_BRANCH;
                        default: state_q <= UNDEF_NEXT;
                    endcase
                end
                S_MEMADR:   state_q <= sbit ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_q <= S_MEMWB;
                S_MEMWB:    state_q <= S_FETCH;
                S_MEMWRITE: state_q <= S_FETCH;
                S_EXECR,
                S_EXECI:    state_q <= is_cmp ? S_FETCH : S_ALUWB;
                S_ALUWB:    state_q <= S_FETCH;
                S_BRANCH:   state_q <= S_FETCH;
                S_HALT:     state_q <= S_HALT;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // Moore output decode; everything is held inactive while reset is asserted
    always_comb begin
        A3Src      = 1'b0;
        AdrSrc     = 1'b0;
        FlagUpdate = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        WD3Src     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        RegSrc     = 2'b00;
        ALUop      = 3'b000;
        ShiftType  = 3'b111;
        state_dbg  = '0;
        if (!reset) begin
            state_dbg = state_q;
            case (state_q)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = 2'b11;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcB   = 2'b11;
                    ResultSrc = 2'b10;
                    RegSrc    = {op == 2'b01, op == 2'b10};
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    RegSrc  = 2'b10;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = 2'b01;
                    RegWrite  = cond_q;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    RegSrc   = 2'b10;
                    MemWrite = cond_q;
                end
                S_EXECR,
                S_EXECI: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                    ALUop      = alu_code;
                    FlagUpdate = cond_q & (sbit | is_cmp);
                    if (state_q == S_EXECR && shamt != 5'd0) begin
                        ShiftType = {1'b0, sh};
                    end
                end
                S_ALUWB: RegWrite = cond_q;
                S_BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    RegSrc    = 2'b01;
                    PCWrite   = cond_q;
                    if (cmd[3]) begin
                        RegWrite = cond_q;
                        A3Src    = 1'b1;
                        WD3Src   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed instructions plus random ones,
// compared cycle by cycle against an instruction-level reference model. Two
// instances (NOP and HALT handling of undefined instructions) share stimulus.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       a3, adr, fu, irw, mw, pcw, rw, wd3;
        logic [1:0] srca, srcb, res, regsrc;
        logic [2:0] aluop, sh;
    } ctl_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = '0;
    logic [3:0]  flags = '0;

    logic       a3 [2], adr [2], fu [2], irw [2], mw [2], pcw [2], rw [2], wd3 [2];
    logic [1:0] srca [2], srcb [2], res [2], rsrc [2];
    logic [2:0] aluop [2], shty [2];
    logic [3:0] dbg [2];
    ctl_t       got [2];

    always #5 clock = ~clock;

    multicycle_control_unit #(.HALT_ON_UNDEF(1'b0)) u_nop (
        .clock(clock), .reset(reset), .INSTRUCTION_OUT(ir), .FLAGS(flags),
        .A3Src(a3[0]), .AdrSrc(adr[0]), .FlagUpdate(fu[0]), .IRWrite(irw[0]),
        .MemWrite(mw[0]), .PCWrite(pcw[0]), .RegWrite(rw[0]), .WD3Src(wd3[0]),
        .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .ResultSrc(res[0]), .RegSrc(rsrc[0]),
        .ALUop(aluop[0]), .ShiftType(shty[0]), .state_dbg(dbg[0])
    );

    multicycle_control_unit #(.HALT_ON_UNDEF(1'b1)) u_halt (
        .clock(clock), .reset(reset), .INSTRUCTION_OUT(ir), .FLAGS(flags),
        .A3Src(a3[1]), .AdrSrc(adr[1]), .FlagUpdate(fu[1]), .IRWrite(irw[1]),
        .MemWrite(mw[1]), .PCWrite(pcw[1]), .RegWrite(rw[1]), .WD3Src(wd3[1]),
        .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .ResultSrc(res[1]), .RegSrc(rsrc[1]),
        .ALUop(aluop[1]), .ShiftType(shty[1]), .state_dbg(dbg[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign got[g] = {a3[g], adr[g], fu[g], irw[g], mw[g], pcw[g], rw[g], wd3[g],
                         srca[g], srcb[g], res[g], rsrc[g], aluop[g], shty[g]};
    end

    int   n_checks = 0;
    int   n_errors = 0;
    ctl_t exp_q [$];
    ctl_t obs [$];

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.sh = 3'b111;
        return c;
    endfunction

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit c = f[1];
        bit v = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: expected control bundle per cycle of one instruction into exp_q.
    // Returns 1 when the instruction is unsupported.
    function automatic bit build_expected(input logic [31:0] i, input logic [3:0] f);
        logic [1:0] op = i[27:26];
        logic [3:0] cmd = i[24:21];
        bit         pass = cond_ok(i[31:28], f);
        bit         known = 1'b1;
        logic [2:0] alu = 3'b000;
        ctl_t       s;
        exp_q.delete();
        s = idle(); s.irw = 1; s.pcw = 1; s.srcb = 2'b11; s.res = 2'b10;
        exp_q.push_back(s);
        s = idle(); s.srcb = 2'b11; s.res = 2'b10;
        s.regsrc = {op == 2'd1, op == 2'd2};
        exp_q.push_back(s);
        case (cmd)
            4'b0100: alu = 3'b000;
            4'b0010: alu = 3'b001;
            4'b0000: alu = 3'b010;
            4'b1100: alu = 3'b011;
            4'b0001: alu = 3'b110;
            4'b1101: alu = 3'b100;
            4'b1010: alu = 3'b001;
            default: known = 1'b0;
        endcase
        if (op == 2'd0 && known) begin
            s = idle(); s.srca = 2'b01; s.srcb = i[25] ? 2'b01 : 2'b00; s.aluop = alu;
            if (!i[25] && i[11:7] != 0) s.sh = {1'b0, i[6:5]};
            s.fu = pass && (i[20] || cmd == 4'b1010);
            exp_q.push_back(s);
            if (cmd != 4'b1010) begin
                s = idle(); s.rw = pass;
                exp_q.push_back(s);
            end
            return 1'b0;
        end else if (op == 2'd1) begin
            s = idle(); s.srca = 2'b01; s.srcb = 2'b01; s.regsrc = 2'b10;
            exp_q.push_back(s);
            if (i[20]) begin
                s = idle(); s.adr = 1;
                exp_q.push_back(s);
                s = idle(); s.adr = 1; s.res = 2'b01; s.rw = pass;
                exp_q.push_back(s);
            end else begin
                s = idle(); s.adr = 1; s.regsrc = 2'b10; s.mw = pass;
                exp_q.push_back(s);
            end
            return 1'b0;
        end else if (op == 2'd2) begin
            s = idle(); s.srcb = 2'b01; s.res = 2'b10; s.regsrc = 2'b01; s.pcw = pass;
            if (cmd[3]) begin s.rw = pass; s.a3 = 1; s.wd3 = 1; end
            exp_q.push_back(s);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cyc(input logic [31:0] i, input logic [3:0] f, input bit r,
                       input ctl_t e0, input ctl_t e1, input string tag);
        @(posedge clock);
        #2;
        ir = i; flags = f; reset = r;
        #2;
        check({tag, "/nop"}, 32'(got[0]), 32'(e0));
        check({tag, "/halt"}, 32'(got[1]), 32'(e1));
        if (r) begin
            check({tag, "/dbg_nop"}, 32'(dbg[0]), 32'd0);
            check({tag, "/dbg_halt"}, 32'(dbg[1]), 32'd0);
        end
        obs.push_back(got[0]);
    endtask

    task automatic run_instr(input logic [31:0] i, input logic [3:0] f, input string tag);
        bit u;
        obs.delete();
        u = build_expected(i, f);
        for (int k = 0; k < exp_q.size(); k++) begin
            cyc(i, (k < 2) ? f : 4'($urandom), 1'b0, exp_q[k], exp_q[k],
                $sformatf("%s c%0d", tag, k));
        end
        if (u) begin
            cyc(i, f, 1'b0, exp_q[0], idle(), {tag, " after0"});
            cyc(i, f, 1'b0, exp_q[1], idle(), {tag, " after1"});
            cyc(i, f, 1'b1, idle(), idle(), {tag, " rst"});
        end
    endtask

    logic [3:0] dp_cmds [7] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b1010};

    initial begin
        logic [31:0] rir;
        int unsigned sel;

        cyc(32'h0, 4'h0, 1'b1, idle(), idle(), "reset");

        run_instr(32'hE5911040, 4'h0, "ldr");
        check("ldr_rw_memread", 32'(obs[3].rw), 32'd0);
        check("ldr_rw_memwb", 32'(obs[4].rw), 32'd1);
        check("ldr_res_memwb", 32'(obs[4].res), 32'd1);

        run_instr(32'hE0210002, 4'h0, "eor");
        check("eor_aluop", 32'(obs[2].aluop), 32'd6);
        check("eor_fu", 32'(obs[2].fu), 32'd0);
        check("eor_rw", 32'(obs[3].rw), 32'd1);

        run_instr(32'hE3510005, 4'h0, "cmp");
        check("cmp_fu", 32'(obs[2].fu), 32'd1);
        check("cmp_aluop", 32'(obs[2].aluop), 32'd1);

        run_instr(32'h0A000002, 4'b0000, "beq_nt");
        check("beq_nt_pcw", 32'(obs[2].pcw), 32'd0);
        run_instr(32'h0A000002, 4'b0100, "beq_t");
        check("beq_t_pcw", 32'(obs[2].pcw), 32'd1);

        run_instr(32'hEB000004, 4'h0, "bl");
        check("bl_link", 32'({obs[2].rw, obs[2].a3, obs[2].wd3, obs[2].pcw}), 32'hF);

        run_instr(32'hEC000000, 4'h0, "undef");
        check("undef_refetch", 32'(obs[2].irw), 32'd1);

        // reset during MEMREAD: no write may complete, FETCH follows
        void'(build_expected(32'hE5911040, 4'h0));
        for (int k = 0; k < 3; k++) begin
            cyc(32'hE5911040, 4'h0, 1'b0, exp_q[k], exp_q[k], $sformatf("rstld c%0d", k));
        end
        cyc(32'hE5911040, 4'h0, 1'b1, idle(), idle(), "rstld reset");
        run_instr(32'hE5911040, 4'h0, "rstld again");

        for (int n = 0; n < 300; n++) begin
            rir = $urandom;
            sel = $urandom_range(0, 9);
            rir[27:26] = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            rir[24:21] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : dp_cmds[$urandom_range(0, 6)];
            if ($urandom_range(0, 2) == 0) rir[31:28] = 4'hE;
            if ($urandom_range(0, 3) == 0) rir[11:7] = 5'd0;
            run_instr(rir, 4'($urandom), $sformatf("rnd%0d %h", n, rir));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
